// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU selects, FSM states and instruction field layout
package cpu_pkg;

    localparam logic [7:0] OPCODE_LOADI = 8'h00;
    localparam logic [7:0] OPCODE_MOV   = 8'h01;
    localparam logic [7:0] OPCODE_ADD   = 8'h02;
    localparam logic [7:0] OPCODE_SUB   = 8'h03;
    localparam logic [7:0] OPCODE_AND   = 8'h04;
    localparam logic [7:0] OPCODE_OR    = 8'h05;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 23;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_MSB   = 15;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_MSB   = 7;
    localparam int SRC2_LSB   = 0;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm_sel;
        logic       neg_sel;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode to ALU select / operand mux decode
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output decode_t    decode_o
);

    always_comb begin
        decode_o = '{aluop: ALU_FWD, imm_sel: 1'b0, neg_sel: 1'b0, illegal: 1'b0};
        case (opcode_i)
            OPCODE_LOADI: decode_o.imm_sel = 1'b1;
            OPCODE_MOV:   decode_o.aluop   = ALU_FWD;
            OPCODE_ADD:   decode_o.aluop   = ALU_ADD;
            OPCODE_SUB: begin
                // subtraction is add with operand 2 negated in the datapath
                decode_o.aluop   = ALU_ADD;
                decode_o.neg_sel = 1'b1;
            end
            OPCODE_AND:   decode_o.aluop   = ALU_AND;
            OPCODE_OR:    decode_o.aluop   = ALU_OR;
            default:      decode_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute/writeback sequencer
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ALU_WAIT = 2,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [31:0] PC,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic        WRITEENABLE,
    output logic [2:0]  ALUOP,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        BUSY,
    output logic        ILLEGAL
);

    localparam logic [3:0]  WAIT_INIT = 4'(ALU_WAIT - 1);
    localparam logic [31:0] PC_INC    = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [2:0]  dest_q, dest_d;
    logic [2:0]  src1_q, src1_d;
    logic [7:0]  src2_q, src2_d;
    logic [2:0]  rr1_q, rr1_d;
    logic [2:0]  rr2_q, rr2_d;
    logic [2:0]  wr_q, wr_d;
    logic [7:0]  imm_q, imm_d;
    logic [2:0]  aluop_q, aluop_d;
    logic        imm_sel_q, imm_sel_d;
    logic        neg_sel_q, neg_sel_d;
    logic        we_q, we_d;
    logic        illegal_q, illegal_d;
    decode_t     dec;

    // Upper register-address bits are architecturally don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{INSTRUCTION[DEST_MSB:DEST_LSB+REG_ADDR_W],
                                INSTRUCTION[SRC1_MSB:SRC1_LSB+REG_ADDR_W]};

    instr_decoder u_decoder (
        .opcode_i (opcode_q),
        .decode_o (dec)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        rr1_d     = rr1_q;
        rr2_d     = rr2_q;
        wr_d      = wr_q;
        imm_d     = imm_q;
        aluop_d   = aluop_q;
        imm_sel_d = imm_sel_q;
        neg_sel_d = neg_sel_q;
        we_d      = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (INSTR_VALID) begin
                    opcode_d = INSTRUCTION[OPCODE_MSB:OPCODE_LSB];
                    dest_d   = INSTRUCTION[DEST_LSB +: REG_ADDR_W];
                    src1_d   = INSTRUCTION[SRC1_LSB +: REG_ADDR_W];
                    src2_d   = INSTRUCTION[SRC2_MSB:SRC2_LSB];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rr1_d     = src1_q;
                rr2_d     = src2_q[REG_ADDR_W-1:0];
                wr_d      = dest_q;
                imm_d     = src2_q;
                aluop_d   = dec.aluop;
                imm_sel_d = dec.imm_sel;
                neg_sel_d = dec.neg_sel;
                if (dec.illegal) begin
                    // skip the ALU wait; writeback runs with the strobe held low
                    illegal_d = 1'b1;
                    state_d   = ST_WRITEBACK;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (cnt_q == 4'd0) begin
                    we_d    = 1'b1;
                    state_d = ST_WRITEBACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRITEBACK: begin
                pc_d    = pc_q + PC_INC;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            cnt_q     <= '0;
            opcode_q  <= '0;
            dest_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rr1_q     <= '0;
            rr2_q     <= '0;
            wr_q      <= '0;
            imm_q     <= '0;
            aluop_q   <= ALU_FWD;
            imm_sel_q <= 1'b0;
            neg_sel_q <= 1'b0;
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            dest_q    <= dest_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            rr1_q     <= rr1_d;
            rr2_q     <= rr2_d;
            wr_q      <= wr_d;
            imm_q     <= imm_d;
            aluop_q   <= aluop_d;
            imm_sel_q <= imm_sel_d;
            neg_sel_q <= neg_sel_d;
            we_q      <= we_d;
            illegal_q <= illegal_d;
        end
    end

    assign INSTR_READY = (state_q == ST_FETCH) && !RESET;
    assign BUSY        = (state_q != ST_FETCH);
    assign PC          = pc_q;
    assign READREG1    = rr1_q;
    assign READREG2    = rr2_q;
    assign WRITEREG    = wr_q;
    assign WRITEENABLE = we_q;
    assign ALUOP       = aluop_q;
    assign IMMEDIATE   = imm_q;
    assign IMM_SEL     = imm_sel_q;
    assign NEG_SEL     = neg_sel_q;
    assign ILLEGAL     = illegal_q;

endmodule
